// File: rtl/seq_signed_divider.sv
// -----------------------------------------------------------------------------
// seq_signed_divider
//   Sequential restoring divider producing one quotient bit per clock.
//   Quotient is truncated toward zero and Remainder takes the sign of the
//   Dividend. It is the inverse of the shift-add multiplier datapath. Its
//   results feed the same binary-to-BCD / 7-segment display path.
//
//   Build option:
//     SEQ_DIV_SIGNED_EN defined   -> two's-complement operands and results.
//     SEQ_DIV_SIGNED_EN undefined -> unsigned operands and results. sign and
//                                    ovf stay 0. Latency is the same.
//
//   Handshake: start is a request pulse. It is sampled only in IDLE or DONE.
//   Dividend/Divisor are captured on the accepting edge. The result is valid
//   while ready=1 and stays valid until the next request is accepted. start is
//   ignored while busy=1. busy and ready are never high together.
//
//   Latency: if the accepting edge is E0, ready rises at E(NBits+1).
//   For a zero divisor, ready rises at E1.
//
//   Ports:
//     clk          in   system clock, rising edge
//     rst          in   asynchronous active-low reset
//     start        in   request pulse
//     Dividend     in   [NBits-1:0] dividend
//     Divisor      in   [NBits-1:0] divisor
//     Quotient     out  [NBits-1:0] quotient (all ones on divide-by-zero)
//     Remainder    out  [NBits-1:0] remainder (Dividend on divide-by-zero)
//     ready        out  result valid (DONE)
//     busy         out  operation in progress (DIV/FIX)
//     div_by_zero  out  divisor was zero for the current result
//     ovf          out  most-negative / -1 overflow
//     sign         out  quotient sign (Dividend MSB ^ Divisor MSB)
//     dbg_state_o  out  [1:0] FSM state: 0 IDLE, 1 DIV, 2 FIX, 3 DONE
// -----------------------------------------------------------------------------
module seq_signed_divider #(
   parameter int NBits   = 8,
   parameter int CntBits = $clog2(NBits) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NBits-1:0] Dividend,
   input  logic [NBits-1:0] Divisor,
   output logic [NBits-1:0] Quotient,
   output logic [NBits-1:0] Remainder,
   output logic             ready,
   output logic             busy,
   output logic             div_by_zero,
   output logic             ovf,
   output logic             sign,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CntBits-1:0] LastIter = CntBits'(NBits - 1);

   state_t             state_q;
   logic [CntBits-1:0] cnt_q;
   logic [NBits:0]     p_q;        // partial remainder, one guard bit
   logic [NBits-1:0]   q_q;        // dividend magnitude, shifted into the quotient
   logic [NBits-1:0]   d_q;        // divisor magnitude
   logic               sa_q;       // dividend sign
   logic               sb_q;       // divisor sign
   logic               ovf_pend_q; // overflow detected at accept, published in FIX
   logic [NBits-1:0]   quot_q;
   logic [NBits-1:0]   rem_q;
   logic               ready_q;
   logic               busy_q;
   logic               dbz_q;
   logic               ovf_q;
   logic               sign_q;

   // Operand conditioning at the accepting edge.
   logic [NBits-1:0] a_mag_d;
   logic [NBits-1:0] b_mag_d;
   logic             a_sgn_d;
   logic             b_sgn_d;
   logic             ovf_d;

`ifdef SEQ_DIV_SIGNED_EN
   // |-2^(NBits-1)| wraps to the same bit pattern. Read as unsigned, that
   // pattern is the correct magnitude, so no extra width is needed.
   always_comb begin
      a_sgn_d = Dividend[NBits-1];
      b_sgn_d = Divisor[NBits-1];
      a_mag_d = a_sgn_d ? (~Dividend + 1'b1) : Dividend;
      b_mag_d = b_sgn_d ? (~Divisor + 1'b1) : Divisor;
      ovf_d   = (Dividend == {1'b1, {(NBits-1){1'b0}}}) && (Divisor == '1);
   end
`else
   always_comb begin
      a_sgn_d = 1'b0;
      b_sgn_d = 1'b0;
      a_mag_d = Dividend;
      b_mag_d = Divisor;
      ovf_d   = 1'b0;
   end
`endif

   // One restoring iteration: shift, trial subtract, keep the difference if it
   // did not go negative.
   logic [NBits:0]   p_shift_d;
   logic [NBits:0]   p_next_d;
   logic [NBits-1:0] q_next_d;
   logic             take_d;

   always_comb begin
      p_shift_d = {p_q[NBits-1:0], q_q[NBits-1]};
      take_d    = (p_shift_d >= {1'b0, d_q});
      p_next_d  = take_d ? (p_shift_d - {1'b0, d_q}) : p_shift_d;
      q_next_d  = {q_q[NBits-2:0], take_d};
   end

   // Result correction applied on the FIX edge. For a zero divisor, q_q still
   // holds the untouched dividend magnitude, so re-applying the dividend sign
   // returns the original Dividend as the remainder.
   logic             dbz_d;
   logic [NBits-1:0] rem_mag_d;
   logic [NBits-1:0] quot_fix_d;
   logic [NBits-1:0] rem_fix_d;

   always_comb begin
      dbz_d     = (d_q == '0);
      rem_mag_d = dbz_d ? q_q : p_q[NBits-1:0];
`ifdef SEQ_DIV_SIGNED_EN
      quot_fix_d = dbz_d ? '1 : ((sa_q ^ sb_q) ? (~q_q + 1'b1) : q_q);
      rem_fix_d  = sa_q ? (~rem_mag_d + 1'b1) : rem_mag_d;
`else
      quot_fix_d = dbz_d ? '1 : q_q;
      rem_fix_d  = rem_mag_d;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         p_q        <= '0;
         q_q        <= '0;
         d_q        <= '0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         ovf_pend_q <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         dbz_q      <= 1'b0;
         ovf_q      <= 1'b0;
         sign_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  q_q        <= a_mag_d;
                  d_q        <= b_mag_d;
                  sa_q       <= a_sgn_d;
                  sb_q       <= b_sgn_d;
                  ovf_pend_q <= ovf_d;
                  p_q        <= '0;
                  cnt_q      <= '0;
                  ready_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= (Divisor == '0) ? S_FIX : S_DIV;
               end
            end
            S_DIV: begin
               p_q   <= p_next_d;
               q_q   <= q_next_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastIter) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               quot_q  <= quot_fix_d;
               rem_q   <= rem_fix_d;
               sign_q  <= sa_q ^ sb_q;
               ovf_q   <= ovf_pend_q;
               dbz_q   <= dbz_d;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign Quotient    = quot_q;
   assign Remainder   = rem_q;
   assign ready       = ready_q;
   assign busy        = busy_q;
   assign div_by_zero = dbz_q;
   assign ovf         = ovf_q;
   assign sign        = sign_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Sequential signed restoring divider. It is the inverse companion of the shift-add multiplier datapath in the P1 design.
- Takes NBits-wide two's-complement dividend and divisor on a start pulse and produces a quotient and remainder one bit per clock.
- Signals completion with a level ready. Results feed the same binary-to-BCD / 7-segment display path used by the multiplier.

Parameters:
- NBits, 8, operand/result width in bits (>=2).
- CntBits, $clog2(NBits)+1, iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- Dividend  input  NBits  two's-complement dividend, sampled on the accepting edge.
- Divisor  input  NBits  two's-complement divisor, sampled on the accepting edge.
- Quotient  output  NBits  two's-complement quotient, truncated toward zero.
- Remainder  output  NBits  two's-complement remainder; takes the sign of Dividend.
- ready  output  1  high while Quotient/Remainder are valid (DONE state).
- busy  output  1  high in DIV and FIX.
- div_by_zero  output  1  Divisor was 0 for the current result.
- ovf  output  1  Dividend = most-negative and Divisor = -1.
- sign  output  1  quotient sign (Dividend MSB XOR Divisor MSB).

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0; every output and internal register is 0.
- States:
  - IDLE: start=1 -> accept.
  - DIV: NBits iterations.
  - FIX: sign correction; results register.
  - DONE: results held; start=1 -> accept.
- Accept edge:
  - Captures |Dividend| and |Divisor| as unsigned NBits magnitudes (|-2^(NBits-1)| = 2^(NBits-1) fits unsigned).
  - Captures both sign bits; clears the NBits+1-bit partial remainder; counter=0; ready=0.
  - Next state is DIV, or FIX directly if Divisor==0.
- DIV iteration, one per edge:
  - P = {P[NBits-1:0], Q[NBits-1]}; Q = Q<<1.
  - If P >= {1'b0,D}: P = P - D and Q[0]=1.
  - counter++. After the edge performing iteration NBits-1 -> FIX.
- FIX edge:
  - Quotient = Q, negated if the signs differ. Remainder = P[NBits-1:0], negated if the Dividend sign = 1.
  - sign, ovf and div_by_zero are registered; ready=1; busy=0; -> DONE.
- Latency: with the accepting edge as E0, ready rises at E(NBits+1), i.e. 9 edges for NBits=8. Divide-by-zero: ready at E1.
- Divide by zero: Quotient = all ones, Remainder = Dividend unchanged, div_by_zero=1, ovf=0.
- Overflow (-2^(NBits-1) / -1): Quotient = 2^(NBits-1) bit pattern (wraps, e.g. 8'h80), Remainder=0, ovf=1.
- start while busy is ignored; the operation in progress is unaffected. Operand changes while busy are ignored (captured values are used).
- start in DONE: accepted on that edge; ready falls on the same edge.
- Outputs hold their last values in DONE and IDLE until the next FIX.
- Reset mid-operation: immediate abort to IDLE with outputs zeroed; no partial result appears.
- busy and ready are never simultaneously 1.

Optional Feature:
- Macro: SEQ_DIV_SIGNED_EN.
- Defined: signed behaviour as above.
- Undefined:
  - Operands are treated as unsigned; no magnitude/negation logic.
  - sign stuck 0; ovf stuck 0.
  - Remainder is the unsigned remainder; divide-by-zero rules are unchanged.
  - Latency is unchanged.

Test Plan (NBits=8, SEQ_DIV_SIGNED_EN defined unless noted):
- Dividend=7, Divisor=2, start pulse -> 9 edges later ready=1, Quotient=8'h03, Remainder=8'h01, sign=0, busy=0.
- Dividend=-7, Divisor=2 -> Quotient=8'hFD (-3), Remainder=8'hFF (-1), sign=1; then Dividend=7, Divisor=-2 -> Quotient=8'hFD, Remainder=8'h01.
- Dividend=-128, Divisor=-1 -> Quotient=8'h80, Remainder=8'h00, ovf=1; Dividend=5, Divisor=0 -> ready at 2nd edge, Quotient=8'hFF, Remainder=8'h05, div_by_zero=1.
- Start 100/7, change operands to 3/3 and pulse start at edge 4 -> result still Quotient=8'h0E, Remainder=8'h02; a start in DONE with 3/3 -> ready drops same edge, then Quotient=1, Remainder=0.
- Start 100/7, drive rst=0 at edge 5 between clock edges -> outputs 0 and busy=0 immediately; after rst=1, next op 9/3 -> Quotient=3, Remainder=0.
- SEQ_DIV_SIGNED_EN undefined: Dividend=8'hF9 (249), Divisor=2 -> Quotient=8'h7C, Remainder=8'h01, sign=0, ovf=0.
